qdiv_seq: RTL and testbench
===========================

# qdiv_seq

Sequential signed fixed-point divider in the same Qm.n two's-complement format as the multiplier in the arithmetic datapath. It computes `(dividend << Q) / divisor` with one quotient bit per clock, using restoring division on magnitudes. It uses a start/busy/done handshake and is the inverse-operation companion to the combinational multiplier, for normalisation and scaling stages where a per-cycle result is not needed.

## Interface
- `N`, default 16: total word width including the sign bit.
- `Q`, default 12: fractional bits.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request. Sampled only when `busy`=0.
- `dividend` input N: two's-complement Q-format numerator. Captured with `start`.
- `divisor` input N: two's-complement Q-format denominator. Captured with `start`.
- `busy` output 1: high while a division is in progress.
- `done` output 1: one-cycle pulse when the results are valid.
- `quotient` output N: two's-complement Q-format result. Held until the next `done`.
- `overflow` output 1: result magnitude does not fit in N-1 bits. Held with `quotient`.
- `div_by_zero` output 1: the divisor was 0. Held with `quotient`.

## Operation
- **States:** IDLE, CALC, FIN.
- **Start acceptance:** `start`=1 is accepted in IDLE or FIN. `busy`=0 in both of those states, so back-to-back operations are legal. `start` in CALC is ignored.
- **On accept:**
  - Latch the result sign = `dividend[N-1]` XOR `divisor[N-1]`.
  - Latch the magnitudes as N-bit values. The most-negative input, 2^(N-1), is represented exactly.
  - Form the numerator = |dividend| << Q, which is N+Q bits.
  - Clear the remainder and the counter.
- **IDLE/FIN transitions on accept:** go to CALC, or go straight to FIN if `divisor`==0.
- **CALC:** one restoring step per cycle, MSB first. The remainder is N+1 bits. After N+Q steps the full N+Q-bit magnitude quotient exists, and the state goes to FIN.
- **Result formatting** (registered on entry to FIN):
  - `overflow` = 1 if any magnitude bit at position N-1 or above is set.
  - The magnitude is truncated to its low N-1 bits; no saturation.
  - If the sign is 1 and the truncated magnitude is nonzero, `quotient` = the two's complement of {0, magnitude}. Otherwise `quotient` = {0, magnitude}, so a zero result is always positive.
  - Rounding is truncation toward zero.
- **Divide by zero:**
  - `div_by_zero`=1 and `overflow`=1.
  - `quotient` = 0x7FFF-style, i.e. {0, all ones}, if `dividend[N-1]`=0.
  - `quotient` = {1, zeros} if `dividend[N-1]`=1.
- **FIN:** `done`=1. Without `start`, go to IDLE.
- **Zero dividend:** no special case; the result is 0 with flags 0.

## Timing
- **Cycle numbering:** `start` is sampled high in cycle 0.
- **Normal path:**
  - `busy`=1 in cycles 1..N+Q.
  - `done`=1 in cycle N+Q+1 (cycle 29 for 16/12).
  - `quotient`, `overflow` and `div_by_zero` update in that same cycle.
- **Divide-by-zero path:** `busy` stays 0 and `done`=1 in cycle 1.
- **Result hold:** outputs stay stable outside the `done` cycle until the next FIN entry.
- **Reset values:** while `rst`=1 at an edge, go to IDLE, and `busy`, `done`, `quotient`, `overflow`, `div_by_zero` and all internal registers are 0.
- **Reset mid-CALC:** the operation is aborted and no `done` is produced.
- **`start` and `rst` in the same cycle:** reset wins.
- **Input stability:** inputs need to be valid only in the accept cycle.

## Structure
- **Shared package `qfmt_pkg`:**
  - the state enum {IDLE, CALC, FIN};
  - a localparam for the iteration count, N+Q;
  - the function computing the two's-complement magnitude, shared with the multiplier.
- **Sub-module `qsign_mag`:** combinational two's-complement to sign/magnitude conversion. Instantiated for each operand, and reused in reverse for the result.
- **Counter:** $clog2(N+Q+1) bits wide.

## Test plan
1. 0x3000 / 0x2000 (3.0/2.0) -> `quotient`=0x1800, flags 0, `done` in cycle 29, `busy` high in cycles 1-28.
2. 0xD000 / 0x2000 (-3.0/2.0) -> 0xE800. 0x1000 / 0x3000 -> 0x0555. 0xF000 / 0x3000 -> 0xFAAB (truncation toward zero).
3. 0x7000 / 0x0800 (7.0/0.5) -> `overflow`=1, `quotient`=0x6000. 0x8000 / 0xF000 (-8.0/-1.0) -> `overflow`=1, `quotient`=0x0000.
4. 0x1000 / 0x0000 -> `done` in cycle 1, `div_by_zero`=1, `overflow`=1, `quotient`=0x7FFF. 0x9000 / 0 -> `quotient`=0x8000.
5. Handshake:
   - `start` pulsed in cycle 10 during CALC -> ignored, and the first result is unaffected.
   - `start` asserted in the `done` cycle -> accepted, and the next `done` follows exactly 29 cycles later.
6. `rst` asserted in cycle 15 of an operation -> all outputs 0 on the next cycle and no `done`. A following 0x0000 / 0x1000 -> `quotient`=0x0000 with flags 0.

Source files
------------

// File: rtl/qfmt_pkg.sv
// Shared Q-format definitions for the arithmetic datapath.
// Divider state encoding and two's-complement magnitude helper.
package qfmt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } qstate_e;

  localparam int QF_N     = 16;
  localparam int QF_Q     = 12;
  localparam int QF_ITERS = QF_N + QF_Q;
  localparam int QF_MAXW  = 64;

  // Callers sign-extend into the wide word; the result is an unsigned magnitude.
  function automatic logic [QF_MAXW-1:0] qfmt_mag(
    input logic [QF_MAXW-1:0] i_v
  );
    return i_v[QF_MAXW-1] ? (~i_v + 64'd1) : i_v;
  endfunction

endpackage

// File: rtl/qsign_mag.sv
// Two's-complement to magnitude conversion; i_neg forces negation,
// which turns the block around into magnitude-to-negative conversion.
module qsign_mag
  import qfmt_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] i_val,
  input  logic         i_neg,
  output logic [N-1:0] o_mag
);

  logic               w_neg;
  logic [QF_MAXW-1:0] w_ext;

  assign w_neg = i_val[N-1] | i_neg;
  assign w_ext = {{(QF_MAXW-N){w_neg}}, i_val};
  assign o_mag = N'(qfmt_mag(w_ext));

endmodule

// File: rtl/qdiv_seq.sv
// Sequential signed Qm.n divider: (dividend << Q) / divisor,
// restoring division on magnitudes, one quotient bit per clock.
module qdiv_seq
  import qfmt_pkg::*;
#(
  parameter int N = 16,
  parameter int Q = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic         overflow,
  output logic         div_by_zero
);

  localparam int ITERS = N + Q;
  localparam int CW    = $clog2(N + Q + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  qstate_e          r_state;
  logic             r_sign;
  logic [N-1:0]     r_den;
  logic [ITERS-1:0] r_num;
  logic [N-1:0]     r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [N-1:0]     r_quo;
  logic             r_ovf;
  logic             r_dbz;

  logic [N-1:0]     w_a_mag;
  logic [N-1:0]     w_b_mag;
  logic [N:0]       w_rem_sh;
  logic             w_ge;
  logic [N-1:0]     w_rem_nx;
  logic [ITERS-1:0] w_qfull;
  logic [N-1:0]     w_res;

  qsign_mag #(.N(N)) u_mag_a (
    .i_val (dividend),
    .i_neg (1'b0),
    .o_mag (w_a_mag)
  );

  qsign_mag #(.N(N)) u_mag_b (
    .i_val (divisor),
    .i_neg (1'b0),
    .o_mag (w_b_mag)
  );

  // Numerator bits shift out of r_num while quotient bits shift in.
  assign w_rem_sh = {r_rem, r_num[ITERS-1]};
  assign w_ge     = w_rem_sh >= {1'b0, r_den};
  assign w_rem_nx = w_ge ? N'(w_rem_sh - {1'b0, r_den})
                         : w_rem_sh[N-1:0];
  assign w_qfull  = {r_num[ITERS-2:0], w_ge};

  // Negating {0, 0} yields 0, so a zero result stays positive.
  qsign_mag #(.N(N)) u_mag_res (
    .i_val ({1'b0, w_qfull[N-2:0]}),
    .i_neg (r_sign),
    .o_mag (w_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sign  <= 1'b0;
      r_den   <= '0;
      r_num   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quo   <= '0;
      r_ovf   <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE, FIN: begin
          if (start) begin
            r_sign <= dividend[N-1] ^ divisor[N-1];
            r_den  <= w_b_mag;
            r_num  <= ITERS'(w_a_mag) << Q;
            r_rem  <= '0;
            r_cnt  <= '0;
            if (divisor == '0) begin
              r_state <= FIN;
              r_done  <= 1'b1;
              r_ovf   <= 1'b1;
              r_dbz   <= 1'b1;
              r_quo   <= dividend[N-1]
                         ? {1'b1, {(N-1){1'b0}}}
                         : {1'b0, {(N-1){1'b1}}};
            end else begin
              r_state <= CALC;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_rem <= w_rem_nx;
          r_num <= w_qfull;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quo   <= w_res;
            r_ovf   <= |w_qfull[ITERS-1:N-1];
            r_dbz   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quo;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_qdiv_seq.sv
// Bench for qdiv_seq: arithmetic reference model with a per-cycle
// compare process, directed vectors and randomized traffic.
module tb_qdiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic        overflow;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int          m_lo      = -1;
  int          m_hi      = -2;
  int          m_done_at = -1;
  logic [17:0] m_pend    = '0;
  logic [17:0] m_cur     = '0;

  qdiv_seq #(.N(16), .Q(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Result packed as {quotient, overflow, div_by_zero}.
  function automatic logic [17:0] model_div(input logic [15:0] a,
                                            input logic [15:0] b);
    longint ma, mb, qm, t;
    logic [15:0] q;
    if (b == 16'h0)
      return {a[15] ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
    ma = a[15] ? 65536 - longint'(a) : longint'(a);
    mb = b[15] ? 65536 - longint'(b) : longint'(b);
    qm = (ma * 4096) / mb;
    t  = qm % 32768;
    q  = (a[15] ^ b[15]) ? 16'((65536 - t) % 65536) : 16'(t);
    return {q, qm >= 32768, 1'b0};
  endfunction

  // Timing model: an accepted op owns cycles k+1..k+28, done at k+29.
  always @(posedge clk) begin
    if (rst) begin
      m_lo = -1; m_hi = -2; m_done_at = -1; m_cur = '0;
    end else if (start && !(cyc >= m_lo && cyc <= m_hi)) begin
      m_pend = model_div(dividend, divisor);
      if (divisor == 16'h0) begin
        m_lo = -1; m_hi = -2; m_done_at = cyc + 1;
      end else begin
        m_lo = cyc + 1; m_hi = cyc + 28; m_done_at = cyc + 29;
      end
    end
    cyc = cyc + 1;
    if (cyc == m_done_at) m_cur = m_pend;
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("busy", 32'(busy), 32'(cyc >= m_lo && cyc <= m_hi));
      chk("done", 32'(done), 32'(cyc == m_done_at));
      chk("quotient", 32'(quotient), 32'(m_cur[17:2]));
      chk("overflow", 32'(overflow), 32'(m_cur[1]));
      chk("div_by_zero", 32'(div_by_zero), 32'(m_cur[0]));
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic eo,
                        input logic ez, input int lat,
                        input int glitch, input bit chain);
    int k0;
    bit seen;
    if (!chain) begin
      @(posedge clk); #2;
    end
    start = 1'b1; dividend = a; divisor = b;
    k0 = cyc;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk); #2;
      start    = (i == glitch);
      dividend = 16'h1234;
      divisor  = 16'h0100;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chk("latency", 32'(cyc - k0), 32'(lat));
        chk("op quotient", 32'(quotient), 32'(eq));
        chk("op overflow", 32'(overflow), 32'(eo));
        chk("op div_by_zero", 32'(div_by_zero), 32'(ez));
      end
    end
    if (!seen) chk("done timeout", 32'(0), 32'(1));
    start = 1'b0;
  endtask

  function automatic logic [15:0] pick();
    unique case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'(16'h1000 << $urandom_range(0, 3));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset quotient", 32'(quotient), 32'(0));

    chk("model 3/2", 32'(model_div(16'h3000, 16'h2000)), 32'({16'h1800, 2'b00}));
    chk("model -1/3", 32'(model_div(16'hF000, 16'h3000)), 32'({16'hFAAB, 2'b00}));
    chk("model -8/-1", 32'(model_div(16'h8000, 16'hF000)), 32'({16'h0000, 2'b10}));
    chk("model -x/0", 32'(model_div(16'h9000, 16'h0000)), 32'({16'h8000, 2'b11}));

    run_op(16'h3000, 16'h2000, 16'h1800, 0, 0, 29, -1, 0);
    run_op(16'hD000, 16'h2000, 16'hE800, 0, 0, 29, -1, 0);
    run_op(16'h1000, 16'h3000, 16'h0555, 0, 0, 29, -1, 0);
    run_op(16'hF000, 16'h3000, 16'hFAAB, 0, 0, 29, -1, 0);
    run_op(16'h7000, 16'h0800, 16'h6000, 1, 0, 29, -1, 0);
    run_op(16'h8000, 16'hF000, 16'h0000, 1, 0, 29, -1, 0);
    run_op(16'h1000, 16'h0000, 16'h7FFF, 1, 1, 1, -1, 0);
    run_op(16'h9000, 16'h0000, 16'h8000, 1, 1, 1, -1, 0);
    run_op(16'h3000, 16'h2000, 16'h1800, 0, 0, 29, 10, 0);
    run_op(16'hD000, 16'h2000, 16'hE800, 0, 0, 29, -1, 0);
    run_op(16'h1000, 16'h3000, 16'h0555, 0, 0, 29, -1, 1);

    // Abort an operation with reset in its cycle 15.
    @(posedge clk); #2;
    start = 1'b1; dividend = 16'h7000; divisor = 16'h0800;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("abort busy", 32'(busy), 32'(0));
    chk("abort done", 32'(done), 32'(0));
    chk("abort quotient", 32'(quotient), 32'(0));
    chk("abort overflow", 32'(overflow), 32'(0));
    chk("abort div_by_zero", 32'(div_by_zero), 32'(0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no done after abort", 32'(done), 32'(0));
    end
    run_op(16'h0000, 16'h1000, 16'h0000, 0, 0, 29, -1, 0);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      rst      = ($urandom_range(0, 249) == 0);
      start    = ($urandom_range(0, 3) == 0);
      dividend = pick();
      divisor  = pick();
    end
    @(posedge clk); #2;
    rst = 1'b0; start = 1'b0;
    repeat (35) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
